// File: rtl/cla_add32_if.sv
// rtl/cla_add32_if.sv - operand/result bundle for the 32-bit registered CLA adder
interface cla_add32_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic [31:0] s;
  logic        c_out;
  logic [31:0] p;
  logic [31:0] g;

  modport master (output a, b, c_in, input s, c_out, p, g);
  modport slave  (input a, b, c_in, output s, c_out, p, g);
endinterface

// File: rtl/cla_add32.sv
// rtl/cla_add32.sv - 32-bit adder, 4-bit CLA groups under a second-level lookahead, registered outputs
module cla_add32 (
  input  logic         clk,
  input  logic         rst,
  cla_add32_if.slave   bus
);
  logic [31:0] pb;
  logic [31:0] gb;
  logic [7:0]  gp;
  logic [7:0]  gg;
  logic [8:0]  gc;
  logic [31:0] bc;

  assign pb = bus.a ^ bus.b;
  assign gb = bus.a & bus.b;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    assign gp[k] = &pb[4*k +: 4];
    assign gg[k] = gb[4*k+3]
                 | (pb[4*k+3] & gb[4*k+2])
                 | (pb[4*k+3] & pb[4*k+2] & gb[4*k+1])
                 | (pb[4*k+3] & pb[4*k+2] & pb[4*k+1] & gb[4*k]);
  end

  // Each group carry is a flat OR of products of GG/GP/c_in; loops unroll at elaboration.
  always_comb begin
    logic acc;
    logic prod;
    gc = '0;
    gc[0] = bus.c_in;
    for (int k = 0; k < 8; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        prod = gg[j];
        for (int m = j + 1; m <= k; m++) prod = prod & gp[m];
        acc = acc | prod;
      end
      prod = bus.c_in;
      for (int m = 0; m <= k; m++) prod = prod & gp[m];
      gc[k+1] = acc | prod;
    end
  end

  // Bit carries inside a group come straight from the group carry-in, again as flat products.
  always_comb begin
    logic acc;
    logic prod;
    bc = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 1'b0;
        for (int j = 0; j < i; j++) begin
          prod = gb[4*k+j];
          for (int m = j + 1; m < i; m++) prod = prod & pb[4*k+m];
          acc = acc | prod;
        end
        prod = gc[k];
        for (int m = 0; m < i; m++) prod = prod & pb[4*k+m];
        bc[4*k+i] = acc | prod;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s     <= '0;
      bus.c_out <= 1'b0;
      bus.p     <= '0;
      bus.g     <= '0;
    end else begin
      bus.s     <= pb ^ bc;
      bus.c_out <= gc[8];
      bus.p     <= pb;
      bus.g     <= gb;
    end
  end
endmodule

// File: tb/tb_cla_add32.sv
// tb/tb_cla_add32.sv - directed and random checks of cla_add32 against a 33-bit arithmetic model
module tb_cla_add32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  cla_add32_if bus ();

  cla_add32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                       input logic full);
    logic [32:0] sum;
    @(negedge clk);
    bus.a    = av;
    bus.b    = bv;
    bus.c_in = ci;
    @(posedge clk);
    #1;
    n_vec++;
    sum = {1'b0, av} + {1'b0, bv} + {32'd0, ci};
    check("sum", {32'd0, bus.s}, {32'd0, sum[31:0]});
    check("c_out", {63'd0, bus.c_out}, {63'd0, sum[32]});
    if (full) begin
      check("p", {32'd0, bus.p}, {32'd0, av ^ bv});
      check("g", {32'd0, bus.g}, {32'd0, av & bv});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s"}, {32'd0, bus.s}, 64'd0);
    check({tag, "_c_out"}, {63'd0, bus.c_out}, 64'd0);
    check({tag, "_p"}, {32'd0, bus.p}, 64'd0);
    check({tag, "_g"}, {32'd0, bus.g}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  mode;
    bus.a    = 32'hFFFF_FFFF;
    bus.b    = 32'h0000_0001;
    bus.c_in = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    check_zero("reset");

    @(negedge clk);
    rst = 1'b0;

    apply(32'h5, 32'h9, 1'b0, 1'b1);
    check("tp1_s_const", {32'd0, bus.s}, 64'h0000_000E);
    check("tp1_p_const", {32'd0, bus.p}, 64'h0000_000C);
    check("tp1_g_const", {32'd0, bus.g}, 64'h0000_0001);
    apply(32'h5, 32'h9, 1'b1, 1'b1);
    check("tp1b_s_const", {32'd0, bus.s}, 64'h0000_000F);
    apply(32'h6, 32'h4, 1'b0, 1'b1);
    check("tp2_s_const", {32'd0, bus.s}, 64'h0000_000A);
    apply(32'h6, 32'h4, 1'b1, 1'b1);
    check("tp2b_s_const", {32'd0, bus.s}, 64'h0000_000B);
    apply(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1);
    check("chain_cin_c_out", {63'd0, bus.c_out}, 64'd1);
    check("chain_cin_p", {32'd0, bus.p}, 64'hFFFF_FFFF);
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    check("chain_ones_s", {32'd0, bus.s}, 64'd0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("max_ci1_s", {32'd0, bus.s}, 64'hFFFF_FFFF);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("max_ci0_s", {32'd0, bus.s}, 64'hFFFF_FFFE);
    check("max_ci0_c_out", {63'd0, bus.c_out}, 64'd1);

    // Reset with live operands, held across two edges, then released.
    @(negedge clk);
    bus.a    = 32'h1234_5678;
    bus.b    = 32'h1111_1111;
    bus.c_in = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    check_zero("rst1");
    @(posedge clk);
    #1;
    n_vec++;
    check_zero("rst2");
    @(negedge clk);
    rst = 1'b0;
    apply(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    check("post_rst_s", {32'd0, bus.s}, 64'h2345_6789);
    check("post_rst_c_out", {63'd0, bus.c_out}, 64'd0);

    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      mode = 2'($urandom_range(0, 3));
      case (mode)
        2'd0:    rb = ~ra;
        2'd1:    rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      apply(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cla_add32.md
Name:
cla_add32

Overview:
- 32-bit registered carry-lookahead adder computing s = a + b + c_in, with carry-out.
- Hierarchical lookahead: 4-bit CLA groups under a second-level lookahead unit; no ripple carry between groups.
- Operand inputs are combinational into the adder; sum, carry-out and the per-bit propagate/generate vectors are registered at the output.
- Used as the integer add datapath element.

Parameters:
- None. Width is fixed at 32; group size is fixed at 4 bits (8 groups).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- a  input  32  operand A, unsigned or two's complement
- b  input  32  operand B
- c_in  input  1  carry into bit 0
- s  output  32  registered sum bits [31:0]
- c_out  output  1  registered carry out of bit 31
- p  output  32  registered per-bit propagate, a ^ b
- g  output  32  registered per-bit generate, a & b

Behaviour:
- Reset:
  - On a rising clk edge with rst = 1, s, c_out, p and g all load 0.
  - Reset overrides any in-flight operand; the result of that cycle is discarded.
  - While rst is held high, outputs stay 0.
  - The first edge after rst deasserts loads the result of the inputs present at that edge.
- Latency:
  - Exactly 1 cycle, with no handshake and no valid signal.
  - Inputs are sampled at each rising edge with rst = 0.
  - The registered outputs reflect those inputs until the next edge.
  - Throughput: one add per cycle.
- Per-bit logic:
  - p[i] = a[i] ^ b[i]
  - g[i] = a[i] & b[i]
- Group level (k = 0..7, bits 4k..4k+3):
  - Group propagate GP[k] = AND of the 4 p bits.
  - Group generate GG[k] = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
- Second level:
  - Group carries are C[0] = c_in and C[k+1] = GG[k] | GP[k]&C[k].
  - Each C[k+1] is expanded as a flat sum-of-products of GG/GP and c_in; it must not be a chain of group-to-group ripple.
  - Inside each group, bit carries are derived from C[k] via 4-bit lookahead equations.
- Sum and carry-out:
  - s[i] = p[i] ^ carry[i].
  - c_out = C[8], the carry out of bit 31.
- Arithmetic rules:
  - Result is modulo 2^32; c_out is the 33rd bit of the unsigned sum.
  - No signed-overflow output.
  - Inputs at X/Z are not a supported condition.
- Equivalence requirement: for all inputs, {c_out, s} == a + b + c_in as a 33-bit unsigned value.

Test Plan:
- a=0x5, b=0x9, c_in=0 -> next edge: s=0x0000000E, c_out=0, p=0x0000000C, g=0x00000001. Then c_in=1 with the same operands -> s=0x0000000F.
- a=0x6, b=0x4, c_in=0 -> s=0x0000000A, c_out=0. With c_in=1 -> s=0x0000000B, c_out=0.
- Full propagate chain, carry-in only: a=0xAAAAAAAA, b=0x55555555, c_in=1 -> s=0x00000000, c_out=1, p=0xFFFFFFFF, g=0.
- Full propagate chain, carry from all-ones: a=0xFFFFFFFF, b=0x00000000, c_in=1 -> s=0x00000000, c_out=1.
- Maximum operands: a=b=0xFFFFFFFF, c_in=1 -> s=0xFFFFFFFF, c_out=1. With c_in=0 -> s=0xFFFFFFFE, c_out=1.
- Reset and randomised check:
  - Hold a=0x12345678, b=0x11111111, assert rst for one edge -> all outputs 0.
  - Deassert rst -> next edge s=0x23456789, c_out=0.
  - Then run 10k random vectors against the 33-bit reference sum with 1-cycle delay.
